seq_alu: RTL

Parametrised, handshaked ALU that extends the combinational AND/ripple-adder datapath with subtraction, logic ops, signed compare, a multi-cycle shift-add multiplier, and status flags. It sits between the decode stage and the register-file write-back. It accepts one operation at a time over a valid/ready handshake and holds its result until write-back consumes it.

---
 rtl/seq_alu_pkg.sv | 27 ++
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu_rc_adder.sv | 21 ++
 rtl/seq_alu.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SLT = 3'd5,
        MUL = 3'd6,
        ILL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Bit positions inside the 4-bit flags vector {Z, N, C, V}.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle between decode, the ALU and write-back.
interface seq_alu_if #(
    parameter int N = 32
);
    logic                 in_valid;
    logic                 in_ready;
    alu_pkg::alu_op_t     op;
    logic [N-1:0]         a;
    logic [N-1:0]         b;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         result;
    logic [3:0]           flags;
    logic                 err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags, err
    );
endinterface

// File: rtl/seq_alu_rc_adder.sv
// N-bit ripple-carry adder, one full-adder cell per bit.
module rc_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[N];
endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/slt, optional shift-add MUL.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise opcode MUL reports err.
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    alu_state_t   state, next_state;
    logic         accept, is_mul;
    logic         in_ready_q, out_valid_q, err_q;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;

    logic [N-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout, add_v;

    logic [N-1:0] sc_result;
    logic         sc_c, sc_v, sc_err;
    logic [3:0]   sc_flags;

    assign accept = bus.in_valid && in_ready_q;

`ifdef SEQ_ALU_MUL_EN
    logic [2*N-1:0] acc, mcand, addend, acc_next;
    logic [N-1:0]   mplier, count, hi_sum;
    logic           unused_hi_cout;
    logic           last_step;
    logic [3:0]     mul_flags;

    assign is_mul    = (bus.op == MUL);
    assign addend    = mplier[0] ? mcand : '0;
    assign last_step = (state == BUSY) && (count == N'(1));

    // High half of the accumulate step; the shared adder supplies the low half and its carry.
    rc_adder #(.N(N)) u_add_hi (
        .a     (acc[2*N-1:N]),
        .b     (addend[2*N-1:N]),
        .c_in  (add_cout),
        .sum   (hi_sum),
        .c_out (unused_hi_cout)
    );

    assign acc_next = {hi_sum, add_sum};

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (acc_next[N-1:0] == '0);
        mul_flags[FLAG_N] = acc_next[N-1];
        mul_flags[FLAG_V] = |acc_next[2*N-1:N];
    end
`else
    assign is_mul = 1'b0;
`endif

    // One adder serves ADD, SUB/SLT (a + ~b + 1) and, while BUSY, the accumulate.
    always_comb begin
        add_a   = bus.a;
        add_b   = bus.b;
        add_cin = 1'b0;
        if (bus.op == SUB || bus.op == SLT) begin
            add_b   = ~bus.b;
            add_cin = 1'b1;
        end
`ifdef SEQ_ALU_MUL_EN
        if (state == BUSY) begin
            add_a   = acc[N-1:0];
            add_b   = addend[N-1:0];
            add_cin = 1'b0;
        end
`endif
    end

    rc_adder #(.N(N)) u_add (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    assign add_v = (bus.a[N-1] == add_b[N-1]) && (add_sum[N-1] != bus.a[N-1]);

    always_comb begin
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_err    = 1'b0;
        case (bus.op)
            ADD, SUB: begin
                sc_result = add_sum;
                sc_c      = add_cout;
                sc_v      = add_v;
            end
            AND:     sc_result = bus.a & bus.b;
            OR:      sc_result = bus.a | bus.b;
            XOR:     sc_result = bus.a ^ bus.b;
            // Signed less-than is the sign of a-b corrected by overflow.
            SLT:     sc_result = {{(N-1){1'b0}}, add_sum[N-1] ^ add_v};
            default: sc_err = 1'b1;
        endcase
        sc_flags         = '0;
        sc_flags[FLAG_Z] = (sc_result == '0);
        sc_flags[FLAG_N] = sc_result[N-1];
        sc_flags[FLAG_C] = sc_c;
        sc_flags[FLAG_V] = sc_v;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = is_mul ? BUSY : DONE;
`ifdef SEQ_ALU_MUL_EN
            BUSY: if (last_step) next_state = DONE;
`endif
            DONE: if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state == IDLE);
            out_valid_q <= (next_state == DONE);
            if (accept && !is_mul) begin
                result_q <= sc_result;
                flags_q  <= sc_flags;
                err_q    <= sc_err;
            end
`ifdef SEQ_ALU_MUL_EN
            else if (last_step) begin
                result_q <= acc_next[N-1:0];
                flags_q  <= mul_flags;
                err_q    <= 1'b0;
            end
`endif
        end
    end

`ifdef SEQ_ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (accept && is_mul) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, bus.a};
            mplier <= bus.b;
            count  <= N'(N);
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - N'(1);
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;
endmodule
